// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision adder datapath:
// field widths, extended-mantissa bit positions and the raw-sum beat type.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 28;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int DATA_W  = 32;

  // Exponent arithmetic is done two bits wider and signed so that both
  // overflow past 255 and underflow below 1 stay visible.
  localparam int XEXP_W = 10;

  localparam int CARRY_BIT  = 27;
  localparam int HIDDEN_BIT = 26;
  localparam int LSB_BIT    = 3;
  localparam int G_BIT      = 2;
  localparam int R_BIT      = 1;
  localparam int S_BIT      = 0;

  typedef logic signed [XEXP_W-1:0] xexp_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mantis;
  } fp_raw_t;

endpackage

// File: rtl/fp_norm_round_if.sv
// Valid/ready bus between the mantissa adder, the normalise/round stage
// and the result consumer.
interface fp_norm_round_if #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_mantis;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;

  modport master (
    output in_valid, in_sign, in_exp, in_mantis, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mantis, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter over the hidden bit and everything below it.
// An all-zero input reports 27.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [HIDDEN_BIT:0] value,
  output logic [4:0]          count
);

  // NOTE: count gets its default before the loop, so no latch is inferred.
  always_comb begin
    count = 5'(HIDDEN_BIT + 1);
    for (int i = 0; i <= HIDDEN_BIT; i++) begin
      if (value[i]) count = 5'(HIDDEN_BIT - i);
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Three-stage normalise, round-to-nearest-even and binary32 pack for the
// adder datapath, with a single global stall driven by the output side.
module fp_norm_round #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input logic            clk,
  input logic            rst,
  fp_norm_round_if.slave bus
);
  import fp_pkg::XEXP_W;
  import fp_pkg::EXP_MAX;
  import fp_pkg::CARRY_BIT;
  import fp_pkg::HIDDEN_BIT;
  import fp_pkg::LSB_BIT;
  import fp_pkg::G_BIT;
  import fp_pkg::R_BIT;
  import fp_pkg::S_BIT;
  import fp_pkg::xexp_t;
  import fp_pkg::fp_raw_t;

  logic en;
  logic v1, v2, v3;

  assign en           = !(v3 && !bus.out_ready);
  assign bus.in_ready = en;
  assign bus.out_valid = v3;

  // ---------------- S1: capture and count ----------------
  fp_raw_t    in_raw;
  logic [4:0] lzc;
  xexp_t      exp_ext;
  xexp_t      exp_adj_in;

  assign in_raw  = {bus.in_sign, bus.in_exp, bus.in_mantis};
  assign exp_ext = xexp_t'({{(XEXP_W - EXP_W){1'b0}}, in_raw.exp});

  fp_lzc u_lzc (
    .value (in_raw.mantis[HIDDEN_BIT:0]),
    .count (lzc)
  );

  assign exp_adj_in = in_raw.mantis[CARRY_BIT] ? exp_ext + 10'sd1
                                               : exp_ext - xexp_t'({5'b0, lzc});

  logic             s1_sign, s1_carry, s1_zero;
  logic [MAN_W-1:0] s1_mantis;
  logic [4:0]       s1_lzc;
  xexp_t            s1_exp_adj;

  // NOTE: sequential state uses <= so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)     v1 <= 1'b0;
    else if (en) v1 <= bus.in_valid;
  end

  // NOTE: datapath registers carry no reset; only the valids and out_data are cleared.
  always_ff @(posedge clk) begin
    if (en && bus.in_valid) begin
      s1_sign    <= in_raw.sign;
      s1_mantis  <= in_raw.mantis;
      s1_carry   <= in_raw.mantis[CARRY_BIT];
      s1_lzc     <= lzc;
      s1_exp_adj <= exp_adj_in;
      s1_zero    <= (in_raw.mantis == '0) || (in_raw.exp == '0);
    end
  end

  // ---------------- S2: shift ----------------
  logic [MAN_W-1:0] shifted;

  // The bit pushed out by the right shift folds into the new sticky.
  assign shifted = s1_carry ? {1'b0, s1_mantis[CARRY_BIT:2], s1_mantis[1] | s1_mantis[0]}
                            : s1_mantis << s1_lzc;

  logic             s2_sign, s2_zero, s2_flush;
  logic [MAN_W-1:0] s2_mantis;
  xexp_t            s2_exp_adj;

  always_ff @(posedge clk) begin
    if (rst)     v2 <= 1'b0;
    else if (en) v2 <= v1;
  end

  always_ff @(posedge clk) begin
    if (en && v1) begin
      s2_sign    <= s1_sign;
      s2_mantis  <= shifted;
      s2_exp_adj <= s1_exp_adj;
      s2_zero    <= s1_zero;
      s2_flush   <= (s1_exp_adj <= 10'sd0);
    end
  end

  // ---------------- S3: round and pack ----------------
  logic        round_inc;
  logic [24:0] sig_sum;
  logic        round_carry;
  xexp_t       exp_round;
  logic [22:0] frac;
  logic [31:0] packed_word;

  assign round_inc   = s2_mantis[G_BIT] &
                       (s2_mantis[R_BIT] | s2_mantis[S_BIT] | s2_mantis[LSB_BIT]);
  assign sig_sum     = {1'b0, s2_mantis[HIDDEN_BIT:LSB_BIT]} + {24'b0, round_inc};
  assign round_carry = sig_sum[24];
  assign exp_round   = s2_exp_adj + xexp_t'({9'b0, round_carry});
  assign frac        = round_carry ? 23'b0 : sig_sum[22:0];

  always_comb begin
    if (s2_zero || s2_flush)
      packed_word = {s2_sign, 31'b0};
    else if (exp_round >= xexp_t'(EXP_MAX))
      packed_word = {s2_sign, 8'hFF, 23'b0};
    else
      packed_word = {s2_sign, exp_round[7:0], frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3           <= 1'b0;
      bus.out_data <= '0;
    end else if (en) begin
      v3 <= v2;
      if (v2) bus.out_data <= packed_word;
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: directed vectors, a scoreboard fed by an
// exact-arithmetic round-to-nearest-even model, backpressure and reset.
module tb_fp_norm_round;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_norm_round_if bus ();

  fp_norm_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int stall_cycles = 0;

  logic [31:0] exp_q[$];
  logic        held_valid = 1'b0;
  logic [31:0] held_data;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] r;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Value-level model: find the leading one, take 24 significant bits from
  // there and round the discarded remainder to nearest, ties to even.
  function automatic logic [31:0] model(input logic s, input logic [7:0] e_in, input logic [27:0] m);
    int          p;
    int          e;
    int          drop;
    logic [63:0] sig;
    logic [63:0] rem;
    logic [63:0] half;
    logic [7:0]  e8;
    logic [22:0] f;
    if (m == 28'd0 || e_in == 8'd0) return {s, 31'b0};
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    e = int'(e_in) + p - 26;
    if (e <= 0) return {s, 31'b0};
    if (p > 23) begin
      drop = p - 23;
      sig  = 64'(m) >> drop;
      rem  = 64'(m) & ((64'd1 << drop) - 64'd1);
      half = 64'd1 << (drop - 1);
      if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
    end else begin
      sig = 64'(m) << (23 - p);
    end
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      e   = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    e8 = e[7:0];
    f  = sig[22:0];
    return {s, e8, f};
  endfunction

  // Single compare process, sampling 1 time unit after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      held_valid = 1'b0;
    end else begin
      if (bus.out_valid && held_valid) check("hold_out_data", bus.out_data, held_data);
      check("in_ready_rule", {31'b0, bus.in_ready}, {31'b0, !(bus.out_valid && !bus.out_ready)});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stray_output: got %h with no beat outstanding", bus.out_data);
        end else begin
          check("result", bus.out_data, exp_q.pop_front());
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        stall_cycles++;
        held_valid = 1'b1;
        held_data  = bus.out_data;
      end else begin
        held_valid = 1'b0;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_sign, bus.in_exp, bus.in_mantis));
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m);
    int guard = 0;
    bus.in_valid  = 1'b1;
    bus.in_sign   = s;
    bus.in_exp    = e;
    bus.in_mantis = m;
    #1;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", guard);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_timed(input string name, input logic s, input logic [7:0] e, input logic [27:0] m);
    int lat;
    send(s, e, m);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check(name, 32'(lat), 32'd3);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls_before;

    vecs[0]  = '{1'b0, 8'd127, 28'h4000000, 32'h3F800000};
    vecs[1]  = '{1'b0, 8'd127, 28'h8000000, 32'h40000000};
    vecs[2]  = '{1'b0, 8'd130, 28'h0800000, 32'h3F800000};
    vecs[3]  = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000};
    vecs[4]  = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002};
    vecs[5]  = '{1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000};
    vecs[6]  = '{1'b0, 8'd254, 28'h8000000, 32'h7F800000};
    vecs[7]  = '{1'b1, 8'd127, 28'h0000000, 32'h80000000};
    vecs[8]  = '{1'b0, 8'd2,   28'h0100000, 32'h00000000};
    vecs[9]  = '{1'b1, 8'd200, 28'h0000001, 32'hD7000000};
    vecs[10] = '{1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000};
    vecs[11] = '{1'b0, 8'd127, 28'h4000005, 32'h3F800001};
    vecs[12] = '{1'b0, 8'd127, 28'h800000C, 32'h40000001};
    vecs[13] = '{1'b0, 8'd127, 28'h8000009, 32'h40000001};
    vecs[14] = '{1'b0, 8'd127, 28'h8000008, 32'h40000000};
    vecs[15] = '{1'b0, 8'd1,   28'h4000000, 32'h00800000};
    vecs[16] = '{1'b0, 8'd1,   28'h2000000, 32'h00000000};
    vecs[17] = '{1'b1, 8'd127, 28'h4000000, 32'hBF800000};

    for (int i = 0; i < NV; i++)
      check($sformatf("model_pin_%0d", i), model(vecs[i].s, vecs[i].e, vecs[i].m), vecs[i].r);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 8'd0;
    bus.in_mantis = 28'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset_out_data", bus.out_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {31'b0, bus.in_ready}, 32'd1);

    send_timed("latency_plain", vecs[0].s, vecs[0].e, vecs[0].m);
    drain();

    for (int i = 0; i < NV; i++) send(vecs[i].s, vecs[i].e, vecs[i].m);
    drain();

    // Six back-to-back beats with the consumer stalled in cycles 4..8.
    stalls_before = stall_cycles;
    fork
      begin
        for (int i = 0; i < 6; i++) send(vecs[i + 9].s, vecs[i + 9].e, vecs[i + 9].m);
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          bus.out_ready = !(c >= 4 && c <= 8);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stall_cycles", 32'(stall_cycles - stalls_before), 32'd5);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send(vecs[i + 1].s, vecs[i + 1].e, vecs[i + 1].m);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midreset_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    repeat (6) @(negedge clk);
    send_timed("latency_after_reset", vecs[4].s, vecs[4].e, vecs[4].m);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
